// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//
// Control FSM for a 1024-point radix-2 in-place FFT core. Walks NUM_STAGES
// stages of BFLY_PER_STAGE butterflies, issuing one read per cycle. Between
// stages it idles for PIPE_DEPTH cycles so the last write of a stage lands
// before the first read of the next one. A PIPE_DEPTH-deep shift register
// produces the write-side copy of every issued read.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   start               begin a transform; only looked at in IDLE
//   abort               synchronous abort back to IDLE from any state
//   busy                high in RUN, DRAIN and DONE (decode of state)
//   done                one-cycle completion pulse (registered)
//   rdEn                read issue valid (decode of state: RUN)
//   stageCount          stage of the current read
//   cycleCount          butterfly index of the current read
//   wrEn                rdEn delayed PIPE_DEPTH cycles
//   wrStageCount        stageCount delayed PIPE_DEPTH cycles
//   wrCycleCount        cycleCount delayed PIPE_DEPTH cycles
//
// Handshake: there is no backpressure. A read is issued in every cycle where
// rdEn=1, and the matching write is presented exactly PIPE_DEPTH cycles later
// with wrEn=1; downstream must accept it in that cycle. start is a level
// sampled only in IDLE, so holding it high has no effect while busy.

module fft_stage_sequencer #(
    parameter int NUM_STAGES     = 10,
    parameter int BFLY_PER_STAGE = 512,
    parameter int PIPE_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       rdEn,
    output logic [4:0] stageCount,
    output logic [8:0] cycleCount,
    output logic       wrEn,
    output logic [4:0] wrStageCount,
    output logic [8:0] wrCycleCount
);

    localparam int                 DRAIN_W    = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);
    localparam logic [8:0]         LAST_BFLY  = 9'(BFLY_PER_STAGE - 1);
    localparam logic [4:0]         LAST_STAGE = 5'(NUM_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic [DRAIN_W-1:0] drainCount;

    logic       pipeValid [PIPE_DEPTH];
    logic [4:0] pipeStage [PIPE_DEPTH];
    logic [8:0] pipeCycle [PIPE_DEPTH];

    assign busy = (state != IDLE);
    assign rdEn = (state == RUN);

    // Control FSM. abort shares the reset path: no done pulse, counters
    // cleared, back to IDLE on the next cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state      <= IDLE;
            stageCount <= '0;
            cycleCount <= '0;
            drainCount <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    stageCount <= '0;
                    cycleCount <= '0;
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    // The last butterfly holds its index; the return to 0
                    // happens only when the next stage starts.
                    if (cycleCount == LAST_BFLY) begin
                        state      <= DRAIN;
                        drainCount <= '0;
                    end else begin
                        cycleCount <= cycleCount + 9'd1;
                    end
                end
                DRAIN: begin
                    if (drainCount == DRAIN_LAST) begin
                        if (stageCount == LAST_STAGE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            stageCount <= stageCount + 5'd1;
                            cycleCount <= '0;
                        end
                    end else begin
                        drainCount <= drainCount + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    stageCount <= '0;
                    cycleCount <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write-side delay line. Shifts every cycle regardless of state so the
    // write lags its read by exactly PIPE_DEPTH cycles; abort empties it so
    // in-flight writes are dropped.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                pipeValid[i] <= 1'b0;
                pipeStage[i] <= '0;
                pipeCycle[i] <= '0;
            end
        end else begin
            pipeValid[0] <= rdEn;
            pipeStage[0] <= stageCount;
            pipeCycle[0] <= cycleCount;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                pipeValid[i] <= pipeValid[i-1];
                pipeStage[i] <= pipeStage[i-1];
                pipeCycle[i] <= pipeCycle[i-1];
            end
        end
    end

    assign wrEn         = pipeValid[PIPE_DEPTH-1];
    assign wrStageCount = pipeStage[PIPE_DEPTH-1];
    assign wrCycleCount = pipeCycle[PIPE_DEPTH-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer with default parameters (10 stages,
// 512 butterflies, pipe depth 4). Outputs are packed into one 32-bit vector
//   {busy, done, rdEn, stageCount, cycleCount, wrEn, wrStageCount, wrCycleCount}
// and compared every cycle against a hand-derived timeline: with the start
// cycle as cycle 0, cycle n (k = n-1) belongs to stage k/516; offsets 0..511
// are reads of butterfly k%516, offsets 512..515 are drain cycles holding
// butterfly 511, cycle 5161 is DONE and 5162 is IDLE again. Writes mirror the
// reads four cycles later. Write-side stage/cycle are compared only where a
// write is expected, except after reset where every output is defined.

module tb_fft_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       rdEn;
    logic [4:0] stageCount;
    logic [8:0] cycleCount;
    logic       wrEn;
    logic [4:0] wrStageCount;
    logic [8:0] wrCycleCount;

    int numChecks;
    int numPassed;
    int curCycle;

    fft_stage_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .rdEn         (rdEn),
        .stageCount   (stageCount),
        .cycleCount   (cycleCount),
        .wrEn         (wrEn),
        .wrStageCount (wrStageCount),
        .wrCycleCount (wrCycleCount)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        numChecks++;
        if (obs === expv) begin
            numPassed++;
        end else begin
            $display("FAIL %s at cycle %0d: got %h, want %h", tag, curCycle, obs, expv);
        end
    endtask

    function automatic logic [31:0] obsVec();
        return {busy, done, rdEn, stageCount, cycleCount, wrEn, wrStageCount, wrCycleCount};
    endfunction

    // {rdEn, stage, cycle} of a single transform whose start is at cycle 0.
    function automatic logic [14:0] rdFields(input int n);
        int k;
        int s;
        int r;
        if (n < 1 || n > 5161) return 15'd0;
        if (n == 5161) return {1'b0, 5'd9, 9'd511};
        k = n - 1;
        s = k / 516;
        r = k % 516;
        if (r < 512) return {1'b1, 5'(s), 9'(r)};
        return {1'b0, 5'(s), 9'd511};
    endfunction

    function automatic logic [31:0] expOne(input int n);
        logic b;
        logic d;
        b = (n >= 1) && (n <= 5161);
        d = (n == 5161);
        return {b, d, rdFields(n), rdFields(n - 4)};
    endfunction

    // base2 > 0: a second transform starts at cycle base2.
    // abortAt >= 0: abort/reset sampled at that cycle, everything 0 afterwards.
    function automatic logic [31:0] expAt(input int n, input int base2, input int abortAt);
        if (abortAt >= 0 && n > abortAt) return 32'd0;
        if (base2 > 0 && n > base2) return expOne(n - base2);
        return expOne(n);
    endfunction

    // ---------------- driver ----------------
    // Loop starts with the DUT in IDLE; loop index n is the cycle number
    // relative to the start cycle. Outputs are sampled on the falling edge,
    // then the inputs for that cycle are driven.
    task automatic runSeq(input string name, input int nCycles, input int base2,
                          input bit holdStart, input int abortAt, input bit useRst,
                          input int expRd, input int expWr);
        int rdCount;
        int wrCount;
        logic [31:0] expv;
        logic [31:0] mask;
        rdCount = 0;
        wrCount = 0;
        for (int n = 0; n < nCycles; n++) begin
            @(negedge clk);
            curCycle = n;
            expv = expAt(n, base2, abortAt);
            mask = 32'hFFFF_FFFF;
            if (!expv[14] && !(useRst && abortAt >= 0 && n > abortAt)) mask = ~32'h0000_3FFF;
            checkVal(name, obsVec() & mask, expv & mask);
            if (rdEn) rdCount++;
            if (wrEn) wrCount++;
            start = (n == 0) || (holdStart && n < 2 * base2);
            abort = !useRst && (n == abortAt);
            rst   = useRst && (n == abortAt);
        end
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
        if (expRd >= 0) begin
            curCycle = nCycles;
            checkVal({name, "_rd_total"}, 32'(rdCount), 32'(expRd));
            checkVal({name, "_wr_total"}, 32'(wrCount), 32'(expWr));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        numChecks = 0;
        numPassed = 0;
        curCycle  = 0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("reset", obsVec(), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkVal("reset_idle", obsVec(), 32'd0);

        // Full transform: first read at 1, first write at 5, stage boundary
        // at 512..517, done at 5161, IDLE at 5162.
        runSeq("full", 5166, 0, 1'b0, -1, 1'b0, 5120, 5120);

        // start and abort together in IDLE: stays idle.
        runSeq("abort_with_start", 4, 0, 1'b0, 0, 1'b0, -1, -1);

        // abort at stage 3, butterfly 100 (cycle 1 + 3*516 + 100).
        runSeq("abort_mid", 1652, 0, 1'b0, 1649, 1'b0, -1, -1);

        // Fresh transform after the abort must be complete and correct.
        runSeq("after_abort", 5166, 0, 1'b0, -1, 1'b0, 5120, 5120);

        // start held high: ignored while busy, second transform accepted
        // at cycle 5162 (first read 5163).
        runSeq("start_held", 10326, 5162, 1'b1, -1, 1'b0, 10240, 10240);

        // Reset during the drain of stage 7 (cycle 1 + 7*516 + 513).
        runSeq("rst_drain", 4136, 0, 1'b0, 4126, 1'b1, -1, -1);

        $display("%0d/%0d checks passed", numPassed, numChecks);
        $finish;
    end

endmodule
